// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and arbiter FSM state types.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

endpackage

// File: rtl/axi4lite_rr_pick.sv
// Round-robin picker: first requester after index 'last', wrapping modulo NM.
module axi4lite_rr_pick
  import axi4lite_pkg::*;
#(
  parameter int NM = 2,
  parameter int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Scan last+1 .. last+NM so the previous owner is considered last.
    for (int i = 1; i <= NM; i++) begin
      if (!any && req[(int'(last) + i) % NM]) begin
        any = 1'b1;
        idx = IW'((int'(last) + i) % NM);
        grant[(int'(last) + i) % NM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4lite_rr_arbiter.sv
// NM-to-1 AXI4-Lite arbiter: independent round-robin read and write paths,
// one outstanding transaction per path, pure pass-through of the granted slice.
module axi4lite_rr_arbiter
  import axi4lite_pkg::*;
#(
  parameter int NM = 2,
  parameter int N  = 4,
  parameter int AW = 32
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [NM-1:0]   s_awvalid,
  output logic [NM-1:0]   s_awready,
  input  logic [NM*AW-1:0] s_awaddr,
  input  logic [NM*3-1:0] s_awprot,
  input  logic [NM-1:0]   s_wvalid,
  output logic [NM-1:0]   s_wready,
  input  logic [NM*8*N-1:0] s_wdata,
  input  logic [NM*N-1:0] s_wstrb,
  output logic [NM-1:0]   s_bvalid,
  input  logic [NM-1:0]   s_bready,
  output logic [NM*2-1:0] s_bresp,
  input  logic [NM-1:0]   s_arvalid,
  output logic [NM-1:0]   s_arready,
  input  logic [NM*AW-1:0] s_araddr,
  input  logic [NM*3-1:0] s_arprot,
  output logic [NM-1:0]   s_rvalid,
  input  logic [NM-1:0]   s_rready,
  output logic [NM*8*N-1:0] s_rdata,
  output logic [NM*2-1:0] s_rresp,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [AW-1:0]   m_awaddr,
  output logic [2:0]      m_awprot,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [8*N-1:0]  m_wdata,
  output logic [N-1:0]    m_wstrb,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [1:0]      m_bresp,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [AW-1:0]   m_araddr,
  output logic [2:0]      m_arprot,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [8*N-1:0]  m_rdata,
  input  logic [1:0]      m_rresp,
  output logic [NM-1:0]   wr_grant,
  output logic [NM-1:0]   rd_grant
);

  localparam int IW = $clog2(NM);
  localparam int DW = 8 * N;

  wr_state_t     wr_state_reg, wr_state_next;
  rd_state_t     rd_state_reg, rd_state_next;
  logic [NM-1:0] wr_grant_reg, wr_grant_next, rd_grant_reg, rd_grant_next;
  logic [IW-1:0] wr_last_reg, wr_last_next, rd_last_reg, rd_last_next;
  logic          aw_done_reg, aw_done_next, w_done_reg, w_done_next;

  logic [NM-1:0] wr_pick_grant, rd_pick_grant;
  logic [IW-1:0] wr_pick_idx, rd_pick_idx;
  logic          wr_pick_any, rd_pick_any;

  axi4lite_rr_pick #(.NM(NM), .IW(IW)) u_wr_pick (
    .req(s_awvalid), .last(wr_last_reg), .grant(wr_pick_grant), .idx(wr_pick_idx), .any(wr_pick_any)
  );
  axi4lite_rr_pick #(.NM(NM), .IW(IW)) u_rd_pick (
    .req(s_arvalid), .last(rd_last_reg), .grant(rd_pick_grant), .idx(rd_pick_idx), .any(rd_pick_any)
  );

  // While granted, 'last' doubles as the owner index for the muxes.
  logic aw_open, w_open, b_open, ar_open, r_open;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_open = (wr_state_reg == W_ADDR) && !aw_done_reg;
  assign w_open  = (wr_state_reg == W_ADDR) && !w_done_reg;
  assign b_open  = (wr_state_reg == W_RESP);
  assign ar_open = (rd_state_reg == R_ADDR);
  assign r_open  = (rd_state_reg == R_DATA);

  assign m_awvalid = aw_open && s_awvalid[wr_last_reg];
  assign m_awaddr  = aw_open ? s_awaddr[wr_last_reg*AW +: AW] : '0;
  assign m_awprot  = aw_open ? s_awprot[wr_last_reg*3 +: 3] : '0;
  assign m_wvalid  = w_open && s_wvalid[wr_last_reg];
  assign m_wdata   = w_open ? s_wdata[wr_last_reg*DW +: DW] : '0;
  assign m_wstrb   = w_open ? s_wstrb[wr_last_reg*N +: N] : '0;
  assign m_bready  = b_open && s_bready[wr_last_reg];
  assign m_arvalid = ar_open && s_arvalid[rd_last_reg];
  assign m_araddr  = ar_open ? s_araddr[rd_last_reg*AW +: AW] : '0;
  assign m_arprot  = ar_open ? s_arprot[rd_last_reg*3 +: 3] : '0;
  assign m_rready  = r_open && s_rready[rd_last_reg];

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid && m_rready;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_route
      assign s_awready[gi]          = wr_grant_reg[gi] && aw_open && m_awready;
      assign s_wready[gi]           = wr_grant_reg[gi] && w_open && m_wready;
      assign s_bvalid[gi]           = wr_grant_reg[gi] && b_open && m_bvalid;
      assign s_bresp[gi*2 +: 2]     = (wr_grant_reg[gi] && b_open) ? m_bresp : '0;
      assign s_arready[gi]          = rd_grant_reg[gi] && ar_open && m_arready;
      assign s_rvalid[gi]           = rd_grant_reg[gi] && r_open && m_rvalid;
      assign s_rdata[gi*DW +: DW]   = (rd_grant_reg[gi] && r_open) ? m_rdata : '0;
      assign s_rresp[gi*2 +: 2]     = (rd_grant_reg[gi] && r_open) ? m_rresp : '0;
    end
  endgenerate

  assign wr_grant = wr_grant_reg;
  assign rd_grant = rd_grant_reg;

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_grant_next = wr_grant_reg;
    wr_last_next  = wr_last_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    case (wr_state_reg)
      W_IDLE: if (wr_pick_any) begin
        wr_grant_next = wr_pick_grant;
        wr_last_next  = wr_pick_idx;
        wr_state_next = W_ADDR;
      end
      W_ADDR: begin
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg || w_hs;
        if (aw_done_next && w_done_next) begin
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: if (b_hs) begin
        wr_grant_next = '0;
        wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_grant_next = rd_grant_reg;
    rd_last_next  = rd_last_reg;
    case (rd_state_reg)
      R_IDLE: if (rd_pick_any) begin
        rd_grant_next = rd_pick_grant;
        rd_last_next  = rd_pick_idx;
        rd_state_next = R_ADDR;
      end
      R_ADDR: if (ar_hs) rd_state_next = R_DATA;
      R_DATA: if (r_hs) begin
        rd_grant_next = '0;
        rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_reg <= W_IDLE;
      rd_state_reg <= R_IDLE;
      wr_grant_reg <= '0;
      rd_grant_reg <= '0;
      wr_last_reg  <= IW'(NM - 1);
      rd_last_reg  <= IW'(NM - 1);
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
      wr_grant_reg <= wr_grant_next;
      rd_grant_reg <= rd_grant_next;
      wr_last_reg  <= wr_last_next;
      rd_last_reg  <= rd_last_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
    end
  end

endmodule

// File: tb/tb_axi4lite_rr_arbiter.sv
// Directed bench for axi4lite_rr_arbiter: master BFMs, 4 KiB slave model and a scoreboard monitor.
module tb_axi4lite_rr_arbiter;
  import axi4lite_pkg::*;

  localparam int NM = 2;
  localparam int N  = 4;
  localparam int AW = 32;

  logic ACLK, ARESET;
  logic [NM-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NM-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NM*AW-1:0] s_awaddr, s_araddr;
  logic [NM*3-1:0] s_awprot, s_arprot;
  logic [NM*32-1:0] s_wdata, s_rdata;
  logic [NM*4-1:0] s_wstrb;
  logic [NM*2-1:0] s_bresp, s_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0] m_awprot, m_arprot;
  logic [3:0] m_wstrb;
  logic [1:0] m_bresp, m_rresp;
  logic [NM-1:0] wr_grant, rd_grant;

  axi4lite_rr_arbiter #(.NM(NM), .N(N), .AW(AW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    int          m;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_aw_q[$];
  exp_t exp_w_q[$];
  exp_t exp_b_q[$];
  exp_t exp_r_q[$];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_wr(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] resp, input bit with_b);
    exp_t e;
    e.m = m; e.a = a; e.d = d; e.s = s; e.resp = resp;
    exp_aw_q.push_back(e);
    exp_w_q.push_back(e);
    if (with_b) exp_b_q.push_back(e);
  endtask

  task automatic push_rd(input int m, input logic [31:0] d, input logic [1:0] resp);
    exp_t e;
    e.m = m; e.a = '0; e.d = d; e.s = '0; e.resp = resp;
    exp_r_q.push_back(e);
  endtask

  // Master write BFM; W may lead AW by w_lead cycles; hold_b leaves the B phase untouched.
  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, input bit hold_b);
    bit aw_ok, w_ok, b_ok, hs_aw, hs_w;
    int cyc;
    s_awaddr[m*32 +: 32] = a;
    s_awprot[m*3 +: 3]   = 3'b010;
    s_wdata[m*32 +: 32]  = d;
    s_wstrb[m*4 +: 4]    = s;
    if (w_lead > 0) begin
      s_wvalid[m] = 1'b1;
      repeat (w_lead) begin
        @(negedge ACLK);
        check("w_held_off", s_wready[m], 1'b0);
        @(posedge ACLK); #1;
      end
    end
    s_awvalid[m] = 1'b1;
    s_wvalid[m]  = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 50) begin
      @(negedge ACLK);
      hs_aw = s_awvalid[m] && s_awready[m];
      hs_w  = s_wvalid[m] && s_wready[m];
      @(posedge ACLK); #1;
      if (hs_aw) begin aw_ok = 1'b1; s_awvalid[m] = 1'b0; end
      if (hs_w)  begin w_ok = 1'b1;  s_wvalid[m]  = 1'b0; end
      cyc++;
    end
    check("wr_addr_data_done", {aw_ok, w_ok}, 2'b11);
    if (!hold_b) begin
      s_bready[m] = 1'b1;
      b_ok = 1'b0; cyc = 0;
      while (!b_ok && cyc < 50) begin
        @(negedge ACLK);
        b_ok = s_bvalid[m] && s_bready[m];
        @(posedge ACLK); #1;
        cyc++;
      end
      s_bready[m] = 1'b0;
      check("wr_resp_done", b_ok, 1'b1);
    end
  endtask

  task automatic do_read(input int m, input logic [31:0] a);
    bit hs;
    int cyc;
    s_araddr[m*32 +: 32] = a;
    s_arprot[m*3 +: 3]   = 3'b001;
    s_arvalid[m] = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      hs = s_arvalid[m] && s_arready[m];
      @(posedge ACLK); #1;
      cyc++;
    end
    s_arvalid[m] = 1'b0;
    check("rd_addr_done", hs, 1'b1);
    s_rready[m] = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      hs = s_rvalid[m] && s_rready[m];
      @(posedge ACLK); #1;
      cyc++;
    end
    s_rready[m] = 1'b0;
    check("rd_data_done", hs, 1'b1);
  endtask

  // Slave model: 4 KiB memory, DECERR beyond; reads sample memory before same-cycle writes commit.
  logic [31:0] mem [1024];
  logic [31:0] sl_waddr, sl_wd, sl_raddr;
  logic [3:0]  sl_ws;
  bit sl_awg, sl_wg, sl_aw_hs, sl_w_hs, sl_b_hs, sl_ar_hs, sl_r_hs;

  initial begin
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = '0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    sl_awg = 1'b0; sl_wg = 1'b0;
    sl_waddr = '0; sl_wd = '0; sl_ws = '0; sl_raddr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(negedge ACLK);
      sl_aw_hs = m_awvalid && m_awready;
      sl_w_hs  = m_wvalid && m_wready;
      sl_b_hs  = m_bvalid && m_bready;
      sl_ar_hs = m_arvalid && m_arready;
      sl_r_hs  = m_rvalid && m_rready;
      if (sl_aw_hs) sl_waddr = m_awaddr;
      if (sl_w_hs) begin sl_wd = m_wdata; sl_ws = m_wstrb; end
      if (sl_ar_hs) sl_raddr = m_araddr;
      @(posedge ACLK); #1;
      if (ARESET) begin
        sl_awg = 1'b0; sl_wg = 1'b0;
        m_bvalid = 1'b0; m_bresp = '0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
      end else begin
        if (sl_r_hs) m_rvalid = 1'b0;
        if (sl_ar_hs) begin
          m_rvalid = 1'b1;
          if (sl_raddr < 32'd4096) begin m_rdata = mem[sl_raddr[11:2]]; m_rresp = RESP_OKAY; end
          else begin m_rdata = '0; m_rresp = RESP_DECERR; end
        end
        if (sl_b_hs) m_bvalid = 1'b0;
        if (sl_aw_hs) sl_awg = 1'b1;
        if (sl_w_hs)  sl_wg  = 1'b1;
        if (sl_awg && sl_wg) begin
          if (sl_waddr < 32'd4096) begin
            for (int b = 0; b < 4; b++)
              if (sl_ws[b]) mem[sl_waddr[11:2]][b*8 +: 8] = sl_wd[b*8 +: 8];
            m_bresp = RESP_OKAY;
          end else m_bresp = RESP_DECERR;
          m_bvalid = 1'b1;
          sl_awg = 1'b0; sl_wg = 1'b0;
        end
      end
      m_awready = !sl_awg && !m_bvalid;
      m_wready  = !sl_wg && !m_bvalid;
      m_arready = !m_rvalid;
    end
  end

  // Scoreboard monitor: pops an expectation whenever a handshake is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (m_awvalid && m_awready) begin
          check("aw_expected", exp_aw_q.size() != 0, 1'b1);
          if (exp_aw_q.size() != 0) begin
            e = exp_aw_q.pop_front();
            check("aw_addr", m_awaddr, e.a);
            check("aw_owner", wr_grant, 64'(1) << e.m);
          end
        end
        if (m_wvalid && m_wready) begin
          check("w_expected", exp_w_q.size() != 0, 1'b1);
          if (exp_w_q.size() != 0) begin
            e = exp_w_q.pop_front();
            check("w_data", {m_wstrb, m_wdata}, {e.s, e.d});
          end
        end
        for (int i = 0; i < NM; i++) begin
          if (s_bvalid[i] && s_bready[i]) begin
            $display("B  master %0d resp %0d", i, s_bresp[i*2 +: 2]);
            check("b_expected", exp_b_q.size() != 0, 1'b1);
            if (exp_b_q.size() != 0) begin
              e = exp_b_q.pop_front();
              check("b_owner", i, e.m);
              check("b_route", s_bvalid, 64'(1) << i);
              check("b_resp", s_bresp[i*2 +: 2], e.resp);
            end
          end
          if (s_rvalid[i] && s_rready[i]) begin
            $display("R  master %0d resp %0d data %08h", i, s_rresp[i*2 +: 2], s_rdata[i*32 +: 32]);
            check("r_expected", exp_r_q.size() != 0, 1'b1);
            if (exp_r_q.size() != 0) begin
              e = exp_r_q.pop_front();
              check("r_owner", i, e.m);
              check("r_route", s_rvalid, 64'(1) << i);
              check("r_resp_data", {s_rresp[i*2 +: 2], s_rdata[i*32 +: 32]}, {e.resp, e.d});
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    s_awvalid = '0; s_awaddr = '0; s_awprot = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = '0; s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_rready = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_grants", {wr_grant, rd_grant}, '0);
    check("rst_s_hs", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, '0);
    check("rst_m_hs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, '0);
    check("rst_payload", {m_awaddr, m_wdata}, '0);
    ARESET = 1'b0;

    // Single write from master 1
    push_wr(1, 32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY, 1'b1);
    fork
      do_write(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      begin
        @(negedge ACLK);
        check("t1_grant_latency", wr_grant, 2'b00);
        @(negedge ACLK);
        check("t1_grant", wr_grant, 2'b10);
        check("t1_awaddr", m_awaddr, 32'h10);
        check("t1_m0_no_ready", {s_awready[0], s_wready[0]}, 2'b00);
      end
    join

    // Contention twice: rotation must serve 0 then 1 both times
    for (int k = 0; k < 2; k++) begin
      push_wr(0, 32'(k*8),     32'h1111_0000 + 32'(k), 4'hF, RESP_OKAY, 1'b1);
      push_wr(1, 32'(k*8 + 4), 32'h2222_0000 + 32'(k), 4'hF, RESP_OKAY, 1'b1);
      fork
        do_write(1, 32'(k*8 + 4), 32'h2222_0000 + 32'(k), 4'hF, 0, 1'b0);
        do_write(0, 32'(k*8),     32'h1111_0000 + 32'(k), 4'hF, 0, 1'b0);
      join
    end

    // W ahead of AW by three cycles
    push_wr(0, 32'h14, 32'h0BADF00D, 4'hF, RESP_OKAY, 1'b1);
    do_write(0, 32'h14, 32'h0BADF00D, 4'hF, 3, 1'b0);

    // Concurrent read and write to the same address
    push_wr(0, 32'h20, 32'h12345678, 4'hF, RESP_OKAY, 1'b1);
    do_write(0, 32'h20, 32'h12345678, 4'hF, 0, 1'b0);
    push_rd(0, 32'h12345678, RESP_OKAY);
    push_wr(1, 32'h20, 32'hA5A5A5A5, 4'h3, RESP_OKAY, 1'b1);
    fork
      do_read(0, 32'h20);
      do_write(1, 32'h20, 32'hA5A5A5A5, 4'h3, 0, 1'b0);
      begin
        @(negedge ACLK);
        @(negedge ACLK);
        check("t4_both_grants", {wr_grant, rd_grant}, 4'b1001);
      end
    join
    push_rd(0, 32'h1234A5A5, RESP_OKAY);
    do_read(0, 32'h20);

    // Error pass-through beyond the 4 KiB slave, plus an in-range read back
    push_rd(1, 32'h0, RESP_DECERR);
    do_read(1, 32'h2000);
    push_wr(0, 32'h2000, 32'h55AA55AA, 4'hF, RESP_DECERR, 1'b1);
    do_write(0, 32'h2000, 32'h55AA55AA, 4'hF, 0, 1'b0);
    push_rd(1, 32'hDEADBEEF, RESP_OKAY);
    do_read(1, 32'h10);

    // Reset while B is pending; no completion for the aborted write
    push_wr(1, 32'h30, 32'h77777777, 4'hF, RESP_OKAY, 1'b0);
    do_write(1, 32'h30, 32'h77777777, 4'hF, 0, 1'b1);
    @(negedge ACLK);
    check("t6_b_pending", s_bvalid, 2'b10);
    #2 ARESET = 1'b1;
    #1;
    check("t6_async_clear", {wr_grant, s_bvalid, m_bready, m_awvalid, m_wvalid}, '0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    push_wr(0, 32'h40, 32'h40404040, 4'hF, RESP_OKAY, 1'b1);
    push_wr(1, 32'h44, 32'h44444444, 4'hF, RESP_OKAY, 1'b1);
    fork
      do_write(1, 32'h44, 32'h44444444, 4'hF, 0, 1'b0);
      do_write(0, 32'h40, 32'h40404040, 4'hF, 0, 1'b0);
      begin
        @(negedge ACLK);
        @(negedge ACLK);
        check("t6_first_grant", wr_grant, 2'b01);
      end
    join

    repeat (5) @(posedge ACLK);
    check("aw_q_drained", exp_aw_q.size(), 0);
    check("w_q_drained", exp_w_q.size(), 0);
    check("b_q_drained", exp_b_q.size(), 0);
    check("r_q_drained", exp_r_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi4lite_rr_arbiter.md
Name: axi4lite_rr_arbiter

Overview:
- Shares one AXI4-Lite slave port among NM AXI4-Lite masters.
- Read and write paths are arbitrated independently. Each uses round-robin arbitration with at most one outstanding transaction per path.
- Sits between several master BFMs or DMA engines and one memory-model slave or register block.
- Fully synthesizable. The granted master's channels pass through a registered grant; there is no data buffering.

Parameters:
- NM, 2, number of upstream masters (2..8).
- N, 4, data bus width in bytes (4 or 8).
- AW, 32, address width.

Ports:
- ACLK in 1 clock.
- ARESET in 1 asynchronous, active-high reset.
- s_awvalid/s_awready in/out NM; s_awaddr in NM*AW; s_awprot in NM*3: per-master AW channels.
- s_wvalid/s_wready in/out NM; s_wdata in NM*8*N; s_wstrb in NM*N: per-master W channels.
- s_bvalid/s_bready out/in NM; s_bresp out NM*2: per-master B channels.
- s_arvalid/s_arready in/out NM; s_araddr in NM*AW; s_arprot in NM*3: per-master AR channels.
- s_rvalid/s_rready out/in NM; s_rdata out NM*8*N; s_rresp out NM*2: per-master R channels.
- m_aw*, m_w*, m_b*, m_ar*, m_r*: one AXI4-Lite master port toward the slave, same widths as one s_ slice, opposite directions.
- wr_grant out NM, rd_grant out NM: one-hot current owner; all zeros when idle.

Behaviour:
- Clock and reset: one clock, ACLK. ARESET is asynchronous and active-high.
- Reset values:
  - Both FSMs go to IDLE.
  - Both round-robin pointers last=NM-1, so master 0 wins first.
  - All m_*valid, m_*ready, s_*valid, s_*ready, wr_grant and rd_grant are 0.
  - Payload outputs are 0.
- Write FSM, states W_IDLE, W_ADDR, W_RESP:
  - W_IDLE: the request vector is s_awvalid. If any bit is set, pick the first requester scanning last+1, last+2, … modulo NM. Register it into wr_grant, set last to it, and go to W_ADDR. This costs one cycle of grant latency.
  - W_ADDR:
    - m_aw* = granted s_aw* slice, masked by the aw_done flag. s_awready[g] = m_awready && !aw_done.
    - m_w* = granted s_w* slice, masked by w_done. s_wready[g] = m_wready && !w_done.
    - aw_done and w_done set on their respective handshakes, in any order or in the same cycle.
    - When both are done (or complete this cycle), clear both flags and go to W_RESP.
  - W_RESP: s_bvalid[g] = m_bvalid, s_bresp[g] = m_bresp, m_bready = s_bready[g]. On the B handshake, clear wr_grant and go to W_IDLE. The next grant is earliest on the following cycle.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - Same structure as the write FSM, driven by s_arvalid.
  - R_ADDR ends on the AR handshake.
  - R_DATA ends on the R handshake, routing m_rdata and m_rresp to the granted master.
- Non-granted masters: all their ready and valid outputs are held 0. Their valid signals may stay asserted indefinitely.
- W arriving before AW from a non-granted master is held off (wready=0) until that master wins AW arbitration.
- Read and write FSMs are fully independent. Simultaneous read and write grants, to the same or different masters, are legal.
- Fairness: with all NM requesting continuously, grants rotate 0,1,…,NM-1,0. No master waits more than NM-1 transactions on a path.
- Handshakes: a handshake is valid&&ready sampled on the ACLK rising edge. The arbiter never drops m_*valid before its handshake completes.
- Reset mid-transaction: immediate abandon. All outputs go to their reset values and the pointers reinitialise. No completion is generated for the aborted transaction.
- Responses pass through unmodified, including SLVERR and DECERR.

Decomposition:
- Package axi4lite_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - wr_state_t {W_IDLE,W_ADDR,W_RESP} and rd_state_t {R_IDLE,R_ADDR,R_DATA}.
- Sub-module axi4lite_rr_pick: a parameterised NM round-robin picker.
  - Inputs: req[NM], last index.
  - Outputs: one-hot grant, index, any.
  - Instantiated twice, once for write and once for read.
- The top module holds the FSMs, done flags and muxes.

Test Plan:
1. Single write: master 1 writes addr 0x10, data 0xDEADBEEF, strb 0xF → wr_grant=2'b10 one cycle after awvalid; m_awaddr=0x10; master 1 receives BRESP OKAY; master 0 sees no ready.
2. Contention: both masters assert awvalid at cycle 0, addrs 0x00/0x04 → master 0 is served first, then master 1. A further pair of requests is served 0 then 1 again (rotation holds).
3. W before AW: master 0 drives wvalid 3 cycles before awvalid → s_wready[0] stays 0 until grant; exactly one m_w handshake with the correct data.
4. Concurrent paths: master 0 reads 0x20 while master 1 writes 0x20 → both grants active together; the read returns data from the slave model; no cross-routing of R or B.
5. Error pass-through: read of addr 0x2000 beyond a 4096-byte slave → the requesting master receives RRESP=DECERR, rdata 0.
6. Reset mid-write: assert ARESET during W_RESP with bvalid pending → outputs are 0 asynchronously; after release, master 0 is granted first on new requests.
